// File: rtl/dram_rqst_splitter_pkg.sv
// Shared definitions for the DRAM request splitter and the master controller's field extraction.
package dram_rqst_splitter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  localparam int unsigned ADDR_W      = 32;
  localparam int unsigned LEN_W       = 12;
  localparam int unsigned RQST_W      = ADDR_W + LEN_W + 1;

  // Bit positions of the packed request entry {addr, len, rnw}
  localparam int unsigned ADDR_MSB    = 44;
  localparam int unsigned LEN_MSB     = 12;
  localparam int unsigned RNW_BIT     = 0;

  // Commands must be aligned to this many bytes in both address and length
  localparam int unsigned ALIGN_BYTES = 16;
  localparam int unsigned ALIGN_BITS  = $clog2(ALIGN_BYTES);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [LEN_W-1:0]  len;
    logic              rnw;
  } dram_rqst_t;

endpackage

// File: rtl/dram_rqst_splitter.sv
// Splits one DMA command into boundary-aligned PLB bursts and tracks their completion.
module dram_rqst_splitter
  import dram_rqst_splitter_pkg::*;
#(
  parameter int unsigned DRAM_RQST_FIFO_DATA_WIDTH = 45,
  parameter int unsigned MAX_BURST_BYTES           = 128,
  parameter int unsigned CMD_LEN_WIDTH             = 24,
  parameter int unsigned OUTSTANDING_WIDTH         = 20
) (
  input  logic                                 Bus2IP_Clk,
  input  logic                                 Bus2IP_Reset,
  input  logic                                 i_cmd_valid,
  output logic                                 o_cmd_ready,
  input  logic [31:0]                          i_cmd_addr,
  input  logic [CMD_LEN_WIDTH-1:0]             i_cmd_bytes,
  input  logic                                 i_cmd_rnw,
  output logic [DRAM_RQST_FIFO_DATA_WIDTH-1:0] o_dram_rqst_fifo_data,
  output logic                                 o_dram_rqst_fifo_we,
  input  logic                                 i_dram_rqst_fifo_full,
  input  logic                                 i_rqst_complete,
  output logic                                 o_busy,
  output logic                                 o_done,
  output logic                                 o_err
);

  localparam int unsigned BURST_BITS = $clog2(MAX_BURST_BYTES);
  localparam int unsigned BND_W      = BURST_BITS + 1;

  state_e                       state, state_nxt;
  logic [ADDR_W-1:0]            addr_q, addr_d;
  logic [CMD_LEN_WIDTH-1:0]     remaining_q, remaining_d;
  logic                         rnw_q, rnw_d;
  logic [OUTSTANDING_WIDTH-1:0] outstanding_q, outstanding_d;
  logic                         done_q, done_d;
  logic                         err_q, err_d;

  logic [BND_W-1:0]             boundary;
  logic [CMD_LEN_WIDTH-1:0]     chunk;
  logic                         cmd_bad;
  logic                         push;
  logic                         cpl;
  dram_rqst_t                   rqst;

  // Largest burst that fits the remaining bytes without crossing a burst-aligned boundary
  always_comb begin
    boundary = BND_W'(MAX_BURST_BYTES) - BND_W'(addr_q[BURST_BITS-1:0]);
    chunk    = (remaining_q < CMD_LEN_WIDTH'(boundary)) ? remaining_q
                                                        : CMD_LEN_WIDTH'(boundary);
    cmd_bad  = (i_cmd_addr[ALIGN_BITS-1:0] != '0) ||
               (i_cmd_bytes[ALIGN_BITS-1:0] != '0) ||
               (i_cmd_bytes == '0);
    rqst.addr = addr_q;
    rqst.len  = LEN_W'(chunk);
    rqst.rnw  = rnw_q;
  end

  // Next-state, datapath update and pulse generation
  always_comb begin
    state_nxt     = state;
    addr_d        = addr_q;
    remaining_d   = remaining_q;
    rnw_d         = rnw_q;
    outstanding_d = outstanding_q;
    done_d        = 1'b0;
    err_d         = 1'b0;
    push          = 1'b0;
    cpl           = i_rqst_complete && (state != ST_IDLE);

    case (state)
      ST_IDLE: begin
        if (i_cmd_valid) begin
          if (cmd_bad) begin
            err_d = 1'b1;
          end else begin
            addr_d        = i_cmd_addr;
            remaining_d   = i_cmd_bytes;
            rnw_d         = i_cmd_rnw;
            outstanding_d = '0;
            state_nxt     = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        push = !i_dram_rqst_fifo_full;
        if (push) begin
          addr_d      = addr_q + ADDR_W'(chunk);
          remaining_d = remaining_q - chunk;
          if (remaining_q == chunk) state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (outstanding_q == '0) begin
          done_d    = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase

    // A push and a completion in the same cycle cancel; decrement saturates at zero
    if (push && !cpl) begin
      outstanding_d = outstanding_q + OUTSTANDING_WIDTH'(1);
    end else if (!push && cpl && (outstanding_q != '0)) begin
      outstanding_d = outstanding_q - OUTSTANDING_WIDTH'(1);
    end
  end

  // State register
  always_ff @(posedge Bus2IP_Clk or posedge Bus2IP_Reset) begin
    if (Bus2IP_Reset) state <= ST_IDLE;
    else              state <= state_nxt;
  end

  // Datapath and pulse registers
  always_ff @(posedge Bus2IP_Clk or posedge Bus2IP_Reset) begin
    if (Bus2IP_Reset) begin
      addr_q        <= '0;
      remaining_q   <= '0;
      rnw_q         <= 1'b0;
      outstanding_q <= '0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      addr_q        <= addr_d;
      remaining_q   <= remaining_d;
      rnw_q         <= rnw_d;
      outstanding_q <= outstanding_d;
      done_q        <= done_d;
      err_q         <= err_d;
    end
  end

  assign o_cmd_ready           = (state == ST_IDLE);
  assign o_busy                = (state != ST_IDLE);
  assign o_dram_rqst_fifo_we   = push;
  assign o_dram_rqst_fifo_data = (state == ST_ISSUE) ? DRAM_RQST_FIFO_DATA_WIDTH'(rqst) : '0;
  assign o_done                = done_q;
  assign o_err                 = err_q;

endmodule
